// File: rtl/multu_seq_if.sv
// Handshake and result bus between the pipeline control and the MULTU sequencer.
interface multu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       Signal;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] dataOut;

    modport master (
        output start, Signal, dataA, dataB,
        input  busy, done, hi, lo, dataOut
    );

    modport slave (
        input  start, Signal, dataA, dataB,
        output busy, done, hi, lo, dataOut
    );
endinterface

// File: rtl/multu_seq_ctrl.sv
// Shift-add sequencer for MULTU with HI/LO commit and MFHI/MFLO read port.
// Optional macro MULTU_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are zero.
module multu_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      reset,
    multu_seq_if.slave bus
);
    localparam logic [5:0]       FN_MULTU = 6'd25;
    localparam logic [5:0]       FN_MFHI  = 6'd16;
    localparam logic [5:0]       FN_MFLO  = 6'd18;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   mcnd;
    logic [2*WIDTH-1:0]   prod_sum;
    logic [WIDTH-1:0]     mpr;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic                 accept;
    logic                 last_iter;

    assign accept   = bus.start && (bus.Signal == FN_MULTU);
    assign prod_sum = prod + (mpr[0] ? mcnd : '0);

`ifdef MULTU_EARLY_EXIT_EN
    // Once no set bits remain above bit 0, further iterations only add zero.
    assign last_iter = (cnt == LAST_CNT) || ((mpr >> 1) == '0);
`else
    assign last_iter = (cnt == LAST_CNT);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.busy  = 1'b1;
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, iterate in RUN, commit the final sum on the exit edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            prod <= '0;
            mcnd <= '0;
            mpr  <= '0;
            cnt  <= '0;
            hi_r <= '0;
            lo_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcnd <= {{WIDTH{1'b0}}, bus.dataA};
                        mpr  <= bus.dataB;
                        prod <= '0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    prod <= prod_sum;
                    mcnd <= mcnd << 1;
                    mpr  <= mpr >> 1;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        {hi_r, lo_r} <= prod_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi = hi_r;
    assign bus.lo = lo_r;

    always_comb begin
        bus.dataOut = '0;
        case (bus.Signal)
            FN_MFHI: bus.dataOut = hi_r;
            FN_MFLO: bus.dataOut = lo_r;
            default: bus.dataOut = '0;
        endcase
    end
endmodule

// File: tb/tb_multu_seq_ctrl.sv
// Randomized self-checking bench for multu_seq_ctrl against a product/latency reference model.
module tb_multu_seq_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    multu_seq_if #(.WIDTH(32)) bus ();

    multu_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Number of RUN cycles the reference expects for a given multiplier.
    function automatic int exp_iters(input logic [31:0] b);
`ifdef MULTU_EARLY_EXIT_EN
        int h;
        h = 0;
        for (int i = 0; i < 32; i++) if (b[i]) h = i;
        return h + 1;
`else
        return 32;
`endif
    endfunction

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input string nm);
        logic [63:0] expv;
        int lat;
        int c;
        bit seen;
        expv = {32'd0, a} * {32'd0, b};
        lat  = exp_iters(b);
        bus.Signal = 6'd25; bus.dataA = a; bus.dataB = b; bus.start = 1'b1;
        step();
        bus.start = 1'b0; bus.dataA = $urandom; bus.dataB = $urandom;
        c = 1; seen = 0;
        while (!seen && c <= 100) begin
            if (bus.busy !== 1'b1) begin
                errors++; checks++;
                $display("FAIL %s busy cycle %0d: got %b want 1", nm, c, bus.busy);
            end
            if (bus.done === 1'b1) seen = 1;
            else begin step(); c++; end
        end
        checks++;
        if (!seen || c != lat + 1) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d want %0d (seen=%0d)", nm, c, lat + 1, seen);
        end
        if (seen) begin
            checks++;
            if ({bus.hi, bus.lo} !== expv) begin
                errors++;
                $display("FAIL %s product: got %h_%h want %h", nm, bus.hi, bus.lo, expv);
            end
        end
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || {bus.hi, bus.lo} !== expv) begin
            errors++;
            $display("FAIL %s after_done: busy=%b done=%b hilo=%h want 0 0 %h",
                     nm, bus.busy, bus.done, {bus.hi, bus.lo}, expv);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.start = 1'b1; bus.Signal = 6'd25; bus.dataA = 32'd3; bus.dataB = 32'd5;
        step(); step();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        bus.start = 1'b0; bus.Signal = 6'd16;
        #1;
        checks++;
        if (bus.dataOut !== 32'd0) begin
            errors++; $display("FAIL reset_dataout: got %h want 0", bus.dataOut);
        end
        reset = 1'b0;
        step();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_start_collision: busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        do_mul(32'd3, 32'd5, "basic_3x5");
        bus.Signal = 6'd18; #1;
        checks++;
        if (bus.dataOut !== 32'd15) begin
            errors++; $display("FAIL mflo_read: got %h want 0000000f", bus.dataOut);
        end
        bus.Signal = 6'd16; #1;
        checks++;
        if (bus.dataOut !== 32'd0) begin
            errors++; $display("FAIL mfhi_read: got %h want 0", bus.dataOut);
        end
        bus.Signal = 6'd25; #1;
        checks++;
        if (bus.dataOut !== 32'd0) begin
            errors++; $display("FAIL other_read: got %h want 0", bus.dataOut);
        end
    endtask

    task automatic test_max();
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max_operands");
        bus.Signal = 6'd16; #1;
        checks++;
        if (bus.dataOut !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL max_mfhi: got %h want fffffffe", bus.dataOut);
        end
    endtask

    task automatic test_noop();
        logic [31:0] h0, l0;
        h0 = bus.hi; l0 = bus.lo;
        for (int k = 0; k < 2; k++) begin
            bus.Signal = (k == 0) ? 6'd16 : 6'd0;
            bus.dataA = 32'd11; bus.dataB = 32'd13; bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            for (int c = 0; c < 5; c++) begin
                checks++;
                if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== h0 || bus.lo !== l0) begin
                    errors++;
                    $display("FAIL noop_start code=%0d: busy=%b done=%b hi=%h lo=%h want 0 0 %h %h",
                             bus.Signal, bus.busy, bus.done, bus.hi, bus.lo, h0, l0);
                end
                step();
            end
        end
    endtask

    task automatic test_start_ignored();
        int lat, pc, dones, donec;
        do_mul(32'd7, 32'd6, "prior_7x6");
        lat = exp_iters(32'd200);
        pc  = (lat < 10) ? lat : 10;
        bus.Signal = 6'd25; bus.dataA = 32'd100; bus.dataB = 32'd200; bus.start = 1'b1;
        step();
        bus.start = 1'b0; bus.Signal = 6'd18;
        dones = 0; donec = 0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 1) begin
                #1;
                checks++;
                if (bus.dataOut !== 32'd42) begin
                    errors++; $display("FAIL run_old_lo: got %0d want 42", bus.dataOut);
                end
            end
            if (c == pc) begin
                bus.Signal = 6'd25; bus.dataA = 32'd9; bus.dataB = 32'd9; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0; bus.Signal = 6'd18;
            end
            if (bus.done === 1'b1) begin dones++; donec = c; end
            step();
        end
        bus.start = 1'b0;
        checks++;
        if (dones != 1 || donec != lat + 1) begin
            errors++;
            $display("FAIL busy_start_ignored: dones=%0d at %0d want 1 at %0d", dones, donec, lat + 1);
        end
        checks++;
        if (bus.lo !== 32'd20000 || bus.hi !== 32'd0) begin
            errors++; $display("FAIL ignored_result: hi=%h lo=%h want 0 00004e20", bus.hi, bus.lo);
        end
    endtask

    task automatic test_reset_mid();
        int lat, rc;
        do_mul(32'd7, 32'd6, "prior_7x6_b");
        lat = exp_iters(32'd10);
        rc  = (lat < 15) ? lat : 15;
        bus.Signal = 6'd25; bus.dataA = 32'd10; bus.dataB = 32'd10; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c < rc; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        for (int c = 0; c < 40; c++) begin
            if (bus.done !== 1'b0 || bus.lo !== 32'd0) begin
                errors++; checks++;
                $display("FAIL mid_reset_discard: done=%b lo=%h want 0 0", bus.done, bus.lo);
            end
            step();
        end
        do_mul(32'd10, 32'd10, "after_reset_10x10");
    endtask

    task automatic test_early_exit();
        do_mul(32'd7, 32'd2, "early_7x2");
        do_mul(32'd7, 32'd0, "early_7x0");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int n = 0; n < 24; n++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (n % 7 == 3) a = 32'd0;
            do_mul(a, b, "random");
        end
    endtask

    initial begin
        reset = 1'b1; bus.start = 1'b0; bus.Signal = 6'd0; bus.dataA = '0; bus.dataB = '0;
        test_reset();
        test_basic();
        test_max();
        test_noop();
        test_start_ignored();
        test_reset_mid();
        test_early_exit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
